uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional WAIT-state timeout abort is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int HOLD_CYCLES    = 110,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [8*NUM_REQ-1:0]         req_data,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           done,
  output logic                         err,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   owner,
  output logic                         tx_new_data,
  output logic [7:0]                   tx_din,
  input  logic                         tx_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  state_t               state_q;
  logic [IW-1:0]        ptr_q, owner_q;
  logic [NUM_REQ-1:0]   gnt_q, done_q;
  logic                 err_q, busy_q, txnew_q, txd_q;
  logic [7:0]           din_q;
  logic [HW-1:0]        hold_q;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]        to_q;
`endif

  logic                 found_d;
  logic [IW-1:0]        sel_d, ptr_d;
  logic [7:0]           byte_d;
  int                   idx;

  // Search upward from ptr, wrapping, for the first active request.
  always_comb begin
    found_d = 1'b0;
    sel_d   = '0;
    byte_d  = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found_d && req[idx]) begin
        found_d = 1'b1;
        sel_d   = IW'(idx);
        byte_d  = req_data[8*idx +: 8];
      end
    end
    ptr_d = (sel_d == IW'(NUM_REQ - 1)) ? '0 : sel_d + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      txnew_q <= 1'b0;
      din_q   <= 8'h00;
      hold_q  <= '0;
      txd_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      txd_q  <= tx_done;
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            gnt_q   <= NUM_REQ'(1) << sel_d;
            din_q   <= byte_d;
            owner_q <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= '0;
            txnew_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (hold_q == HOLD_LAST) begin
            txnew_q <= 1'b0;
            hold_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            to_q    <= '0;
`endif
            state_q <= S_WAIT;
          end else if (hold_q != '1) begin
            hold_q <= hold_q + HW'(1);
          end
        end
        S_WAIT: begin
          // Completion needs a genuine rise; a level already high is not enough.
          if (tx_done && !txd_q) begin
            done_q  <= NUM_REQ'(1) << owner_q;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            state_q <= S_IDLE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (to_q == TO_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            state_q <= S_IDLE;
          end else if (to_q != '1) begin
            to_q <= to_q + TW'(1);
          end
`endif
        end
        default: begin
          busy_q  <= 1'b0;
          txnew_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign tx_new_data = txnew_q;
  assign tx_din      = din_q;

endmodule
